// File: rtl/game_state_ctrl.sv
// Game flow controller: start/play/hit/goal/over sequencing, lives and score
// bookkeeping, and the respawn command to the frog controller.
module game_state_ctrl #(
  parameter int unsigned c_START_LIVES = 3,
  parameter int unsigned c_HIT_FRAMES  = 60,
  parameter int unsigned c_GOAL_ROW    = 0,
  parameter int unsigned c_MAX_SCORE   = 99
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Game_Start,
  input  logic       i_Frame_Tick,
  input  logic       i_Collided,
  input  logic [5:0] i_Frogger_Y,
  output logic       o_Game_Active,
  output logic       o_Respawn,
  output logic [1:0] o_Lives,
  output logic [6:0] o_Score,
  output logic [2:0] o_State
);

  localparam logic [1:0] START_LIVES = 2'(c_START_LIVES);
  localparam logic [7:0] HIT_FRAMES  = 8'(c_HIT_FRAMES);
  localparam logic [5:0] GOAL_ROW    = 6'(c_GOAL_ROW);
  localparam logic [6:0] MAX_SCORE   = 7'(c_MAX_SCORE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_GOAL = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t     state_q;
  logic [1:0] lives_q;
  logic [6:0] score_q;
  logic [7:0] frame_cnt_q;
  logic       start_prev_q;
  logic       respawn_q;
  logic       active_q;

  logic start_edge;
  logic goal_reached;

  assign start_edge   = i_Game_Start & ~start_prev_q;
  assign goal_reached = (i_Frogger_Y == GOAL_ROW);

  // active_q is updated alongside every state change so it tracks state_q
  // with no extra cycle of latency.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q      <= S_IDLE;
      lives_q      <= '0;
      score_q      <= '0;
      frame_cnt_q  <= '0;
      start_prev_q <= 1'b1;
      respawn_q    <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      start_prev_q <= i_Game_Start;
      respawn_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_edge) begin
            lives_q   <= START_LIVES;
            score_q   <= '0;
            respawn_q <= 1'b1;
            state_q   <= S_PLAY;
            active_q  <= 1'b1;
          end
        end
        S_PLAY: begin
          if (i_Collided) begin
            frame_cnt_q <= '0;
            active_q    <= 1'b0;
            if (lives_q <= 2'd1) begin
              lives_q <= '0;
              state_q <= S_OVER;
            end else begin
              lives_q <= lives_q - 2'd1;
              state_q <= S_HIT;
            end
          end else if (goal_reached) begin
            if (score_q < MAX_SCORE) begin
              score_q <= score_q + 7'd1;
            end
            respawn_q <= 1'b1;
            state_q   <= S_GOAL;
            active_q  <= 1'b0;
          end
        end
        S_HIT: begin
          if (i_Frame_Tick) begin
            if (frame_cnt_q + 8'd1 == HIT_FRAMES) begin
              frame_cnt_q <= '0;
              respawn_q   <= 1'b1;
              state_q     <= S_PLAY;
              active_q    <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        S_GOAL: begin
          state_q  <= S_PLAY;
          active_q <= 1'b1;
        end
        default: begin
          state_q  <= S_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Game_Active = active_q;
  assign o_Respawn     = respawn_q;
  assign o_Lives       = lives_q;
  assign o_Score       = score_q;
  assign o_State       = state_q;

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter c_START_LIVES, default 3, lives loaded on game start (1..3).
REQ-002 SHALL have parameter c_HIT_FRAMES, default 60, frame ticks spent in HIT before respawn (1..255).
REQ-003 SHALL have parameter c_GOAL_ROW, default 0, tile row counted as goal reached.
REQ-004 SHALL have parameter c_MAX_SCORE, default 99, score saturation value (fits 7 bits).
REQ-005 SHALL have port i_Clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-006 SHALL have port i_Rst_L  input  1  synchronous active-low reset.
REQ-007 SHALL have port i_Game_Start  input  1  start button level, synchronous to i_Clk.
REQ-008 SHALL have port i_Frame_Tick  input  1  one-cycle pulse per video frame.
REQ-009 SHALL have port i_Collided  input  1  frog/car collision level from collision stage.
REQ-010 SHALL have port i_Frogger_Y  input  6  frog tile row from frogger_ctrl.
REQ-011 SHALL have port o_Game_Active  output  1  high only in PLAY; drives frogger_ctrl i_Game_Active.
REQ-012 SHALL have port o_Respawn  output  1  one-cycle pulse commanding frog return to origin.
REQ-013 SHALL have port o_Lives  output  2  remaining lives.
REQ-014 SHALL have port o_Score  output  7  current score, feeds score_control.
REQ-015 SHALL have port o_State  output  3  encoded state: IDLE=0, PLAY=1, HIT=2, GOAL=3, OVER=4.

Function
REQ-016 SHALL detect start as rising edge of i_Game_Start (registered previous value); level holding SHALL NOT retrigger.
REQ-017 SHALL, in IDLE or OVER on start edge, load o_Lives=c_START_LIVES, o_Score=0, pulse o_Respawn, enter PLAY next cycle.
REQ-018 SHALL ignore start edges in PLAY, HIT, GOAL.
REQ-019 SHALL, in PLAY with i_Collided=1, decrement o_Lives by 1, clear frame counter, enter HIT.
REQ-020 SHALL, when collision occurs with o_Lives=1, set o_Lives=0 and enter OVER instead of HIT.
REQ-021 SHALL, in PLAY with i_Collided=0 and i_Frogger_Y==c_GOAL_ROW, increment o_Score saturating at c_MAX_SCORE, enter GOAL.
REQ-022 SHALL give collision priority over goal when both true in the same cycle (no score change).
REQ-023 SHALL stay in GOAL exactly 1 cycle, pulse o_Respawn in that cycle, return to PLAY.
REQ-024 SHALL, in HIT, count i_Frame_Tick pulses; on the tick making count==c_HIT_FRAMES, pulse o_Respawn and return to PLAY.
REQ-025 SHALL ignore i_Collided and i_Frogger_Y outside PLAY.
REQ-026 SHALL never underflow o_Lives below 0 nor overflow o_Score above c_MAX_SCORE.
REQ-027 SHALL hold o_Lives and o_Score in OVER until a start edge.
REQ-028 SHALL produce all outputs as registers; o_Game_Active SHALL equal (state==PLAY) with no extra latency vs o_State.
REQ-029 SHALL treat unreachable state encodings (5..7) as IDLE on next cycle.

Reset
REQ-030 SHALL, while i_Rst_L=0 at a clock edge, set state IDLE, o_Lives=0, o_Score=0, o_Respawn=0, frame counter 0, start-edge register 1.
REQ-031 SHALL abort any in-progress HIT/GOAL on reset mid-operation, with no o_Respawn pulse emitted.
REQ-032 SHALL NOT start a game from a button already held at reset release (start-edge register reset to 1).

Verification
REQ-033 Reset, release, pulse i_Game_Start 1 cycle -> next cycle o_State=1, o_Lives=3, o_Score=0, one o_Respawn pulse.
REQ-034 In PLAY assert i_Collided 1 cycle -> o_Lives=2, o_State=2; after 60 i_Frame_Tick pulses -> single o_Respawn, o_State=1.
REQ-035 Three collisions with respawns between -> after third o_Lives=0, o_State=4, o_Game_Active=0; start edge -> o_Lives=3, o_Score=0.
REQ-036 In PLAY drive i_Frogger_Y=0 -> o_Score +1, o_State=3 for 1 cycle with o_Respawn, then 1; at o_Score=99 -> stays 99.
REQ-037 i_Collided=1 and i_Frogger_Y=0 same cycle -> o_Lives decremented, o_Score unchanged, o_State=2.
REQ-038 Assert i_Rst_L=0 during HIT with i_Game_Start held through release -> o_State=0, no o_Respawn, stays IDLE until button released and pressed again.
